ws2812b_rx: RTL and testbench
=============================

# ws2812b_rx

Single-wire WS2812B stream decoder: recovers 24-bit GRB pixel words and frame boundaries from the `data_pwm` line produced by the LED driver chain. It sits in the verification/monitor path (and optionally on a board loopback pin), giving benches and on-chip checkers a cycle-accurate view of what the matrix would display. It assumes a 50 MHz `sys_clk`, and every timing parameter is in clock cycles.

## Interface
- `TH_THRESH`, default 30: a high pulse of at least this many cycles decodes as 1; shorter decodes as 0. The 0/1 boundary is 0.6 µs.
- `MIN_HIGH`, default 5: a high pulse shorter than this is a glitch and raises an error.
- `MAX_HIGH`, default 60: a high pulse longer than this is malformed and raises an error.
- `RST_CYC`, default 15000: low time of at least this many cycles is a frame reset (300 µs).
- `NPIX`, default 64: expected pixels per frame (8×8 matrix).
- `sys_clk`, input, 1: system clock. There is one clock domain.
- `sys_rst`, input, 1: reset. It is synchronous and active-high.
- `data_in`, input, 1: raw WS2812B line, asynchronous to `sys_clk`.
- `pix_data`, output, 24: last decoded word, {G[7:0], R[7:0], B[7:0]}, MSB first on the wire.
- `pix_valid`, output, 1: one-cycle strobe that qualifies `pix_data` and `pix_idx`.
- `pix_idx`, output, 7: index of the pixel within the frame, starting at 0.
- `frame_done`, output, 1: one-cycle strobe when a frame reset is detected.
- `frame_pix`, output, 7: pixel count of the frame just closed. Valid with `frame_done`.
- `err`, output, 1: sticky error flag. Cleared only by `sys_rst`.

## Operation
- `data_in` passes through a 2-flop synchronizer and then a rise/fall edge detector. All decoding works on the synchronized signal `d_s`.
- State machine:
  - **S_ALIGN** (reset state): ignores activity until `d_s` has been low for `RST_CYC` consecutive cycles. It then goes to S_IDLE and does NOT pulse `frame_done`.
  - **S_IDLE**: waits for a rising edge, then clears `high_cnt` and goes to S_HIGH.
  - **S_HIGH**: `high_cnt` counts up and saturates at 127.
    - On a falling edge with `MIN_HIGH` ≤ `high_cnt` ≤ `MAX_HIGH`: shift bit (`high_cnt` ≥ `TH_THRESH`) into `shreg` at the LSB, increment `bit_cnt`, clear `low_cnt`, go to S_LOW.
    - On a falling edge with `high_cnt` out of range: set `err`, discard the partial word, go to S_ALIGN.
    - If `high_cnt` exceeds `MAX_HIGH` while still high: set `err` and go to S_ALIGN at once.
  - **S_LOW**: `low_cnt` counts up and saturates at `RST_CYC`.
    - A rising edge before `RST_CYC` starts the next bit (S_HIGH).
    - When `low_cnt` reaches `RST_CYC`: pulse `frame_done` with `frame_pix` = `pix_cnt`, clear `pix_cnt` and `bit_cnt`, go to S_IDLE.
- Word completion:
  - When `bit_cnt` reaches 24, `pix_data` ← `shreg`, `pix_idx` ← `pix_cnt`, pulse `pix_valid`, `pix_cnt` += 1 (saturates at 127), and `bit_cnt` ← 0.
  - `pix_data` holds its value until the next word completes.
- Frame checks at reset detection:
  - `bit_cnt` ≠ 0 (partial pixel): set `err` and drop the partial bits.
  - `pix_cnt` ≠ `NPIX`: `frame_done` still pulses, and `err` is also set.
- `pix_valid` and `frame_done` can never be asserted in the same cycle. A word always completes on a falling edge, and a reset is always at least `RST_CYC` cycles later.

## Timing
- Latency from a raw `data_in` edge to the internal edge strobe is 3 cycles: 2 synchronizer flops plus the edge register.
- `pix_valid` rises 1 cycle after the falling-edge strobe of the 24th bit, so 4 cycles after the raw falling edge.
- `frame_done` rises in the cycle after `low_cnt` reaches `RST_CYC`.
- Nominal bit (50 MHz): 0 is 20 cycles high, 1 is 40 cycles high, period 62–63 cycles. `low_cnt` is not checked against a minimum.
- Reset values:
  - `pix_data` = 0, `pix_valid` = 0, `pix_idx` = 0, `frame_done` = 0, `frame_pix` = 0, `err` = 0.
  - State S_ALIGN, all counters 0.
- Asserting `sys_rst` mid-word or mid-frame discards everything and returns to S_ALIGN on the next edge.
- Counter widths: `high_cnt` 7 bits, `low_cnt` 14 bits, `bit_cnt` 5 bits, `pix_cnt` 7 bits.

## Structure
- Package `ws2812b_rx_pkg`:
  - state enum {S_ALIGN, S_IDLE, S_HIGH, S_LOW};
  - the default cycle constants (`TH_THRESH`, `MIN_HIGH`, `MAX_HIGH`, `RST_CYC`, `NPIX`);
  - width constants and the GRB field offsets (G 23:16, R 15:8, B 7:0).
- Sub-module `sync_edge`: 2-flop synchronizer plus rise/fall strobe generation. It is reused for the key inputs elsewhere.
- The FSM, counters, shift register and frame checks stay in `ws2812b_rx`.

## Test plan
- **Single pixel:** after reset, line low for 15000 cycles, then 24 bits of 0x00FF00 (high 20/40, period 62), then 15000 low. Expect one `pix_valid` with `pix_data` = 0x00FF00 and `pix_idx` = 0, then `frame_done` with `frame_pix` = 1 and `err` = 1 (since `NPIX` = 64).
- **Full frame:** 64 pixels with `pix_data` = index × 0x010101, then a reset gap. Expect 64 strobes with `pix_idx` 0–63 in order, `frame_done` with `frame_pix` = 64, and `err` = 0.
- **Threshold edges:** high widths 29 and 30 cycles decode as 0 and 1. Widths 4 and 61 set `err` and return to S_ALIGN.
- **Partial pixel:** 12 bits followed by a reset gap. Expect `frame_done` with `frame_pix` = 0, `err` = 1, and no `pix_valid`.
- **Startup alignment:** stream begins mid-word with no preceding gap. Expect no `pix_valid` until after the first 15000-cycle low.
- **Reset mid-frame:** assert `sys_rst` for 1 cycle during bit 10 of pixel 3. Expect all outputs at 0, and that the resumed stream is not decoded until the next reset gap.

Source files
------------

// File: rtl/ws2812b_rx_pkg.sv
// Shared types and constants for the WS2812B stream decoder.
// All timing values are in sys_clk cycles (50 MHz nominal).
package ws2812b_rx_pkg;

    typedef enum logic [1:0] {
        S_ALIGN = 2'd0,
        S_IDLE  = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    localparam int TH_THRESH_DEF = 30;
    localparam int MIN_HIGH_DEF  = 5;
    localparam int MAX_HIGH_DEF  = 60;
    localparam int RST_CYC_DEF   = 15000;
    localparam int NPIX_DEF      = 64;

    localparam int HIGH_W = 7;
    localparam int LOW_W  = 14;
    localparam int BIT_W  = 5;
    localparam int PIX_W  = 7;
    localparam int WORD_W = 24;

    // GRB word layout, G sent first on the wire
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus registered
// single-cycle rise/fall strobes; strobes lag the raw input by 3 cycles.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic d_s,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign d_s = s2;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire decoder: recovers 24-bit GRB words and frame resets
// from the LED data line, with a sticky error flag for malformed traffic.
module ws2812b_rx
    import ws2812b_rx_pkg::*;
#(
    parameter int TH_THRESH = TH_THRESH_DEF,
    parameter int MIN_HIGH  = MIN_HIGH_DEF,
    parameter int MAX_HIGH  = MAX_HIGH_DEF,
    parameter int RST_CYC   = RST_CYC_DEF,
    parameter int NPIX      = NPIX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              data_in,
    output logic [WORD_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_idx,
    output logic              frame_done,
    output logic [PIX_W-1:0]  frame_pix,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // pix_valid and frame_done are single-cycle strobes with no backpressure:
    // a consumer must capture pix_data/pix_idx or frame_pix in the strobe cycle.

    localparam logic [7:0]       TH_C   = 8'(TH_THRESH);
    localparam logic [7:0]       MIN_C  = 8'(MIN_HIGH);
    localparam logic [7:0]       MAX_C  = 8'(MAX_HIGH);
    localparam logic [LOW_W-1:0] RST_C  = LOW_W'(RST_CYC);
    localparam logic [PIX_W-1:0] NPIX_C = PIX_W'(NPIX);

    logic d_s;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .d    (data_in),
        .d_s  (d_s),
        .rise (rise),
        .fall (fall)
    );

    state_t              state;
    state_t              state_n;
    logic [HIGH_W-1:0]   high_cnt;
    logic [LOW_W-1:0]    low_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    // Holds the 23 most recent bits; the 24th is merged in on completion
    logic [WORD_W-2:0]   shreg;

    logic [7:0] hw;
    logic       bit_val;
    logic       clr_high;
    logic       do_shift;
    logic       do_frame;
    logic       set_err;
    logic       enter_align;

    // Width including the current cycle, so a fall strobe sees the full pulse
    assign hw      = {1'b0, high_cnt} + 8'd1;
    assign bit_val = (hw >= TH_C);

    always_comb begin
        state_n  = state;
        clr_high = 1'b0;
        do_shift = 1'b0;
        do_frame = 1'b0;
        set_err  = 1'b0;
        case (state)
            S_ALIGN: begin
                if (low_cnt == RST_C) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (rise) begin
                    clr_high = 1'b1;
                    state_n  = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    if (hw >= MIN_C && hw <= MAX_C) begin
                        do_shift = 1'b1;
                        state_n  = S_LOW;
                    end else begin
                        set_err = 1'b1;
                        state_n = S_ALIGN;
                    end
                end else if (hw > MAX_C) begin
                    set_err = 1'b1;
                    state_n = S_ALIGN;
                end
            end
            S_LOW: begin
                if (rise) begin
                    clr_high = 1'b1;
                    state_n  = S_HIGH;
                end else if (low_cnt == RST_C) begin
                    do_frame = 1'b1;
                    set_err  = (bit_cnt != '0) || (pix_cnt != NPIX_C);
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_ALIGN;
        endcase
    end

    assign enter_align = (state_n == S_ALIGN) && (state != S_ALIGN);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_ALIGN;
            high_cnt   <= '0;
            low_cnt    <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            shreg      <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            frame_done <= 1'b0;
            frame_pix  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (set_err) err <= 1'b1;

            if (clr_high) begin
                high_cnt <= '0;
            end else if (state == S_HIGH && high_cnt != '1) begin
                high_cnt <= high_cnt + 1'b1;
            end

            // In S_ALIGN low_cnt measures consecutive low cycles of d_s
            if (enter_align || do_shift) begin
                low_cnt <= '0;
            end else if (state == S_ALIGN) begin
                if (d_s) low_cnt <= '0;
                else if (low_cnt != RST_C) low_cnt <= low_cnt + 1'b1;
            end else if (state == S_LOW && low_cnt != RST_C) begin
                low_cnt <= low_cnt + 1'b1;
            end

            if (do_shift) begin
                shreg <= {shreg[WORD_W-3:0], bit_val};
                if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                    pix_data  <= {shreg, bit_val};
                    pix_idx   <= pix_cnt;
                    pix_valid <= 1'b1;
                    bit_cnt   <= '0;
                    if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (do_frame) begin
                frame_done <= 1'b1;
                frame_pix  <= pix_cnt;
                pix_cnt    <= '0;
                bit_cnt    <= '0;
            end

            if (enter_align) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: drives WS2812B waveforms and checks decoded
// words and frame closes against expected queues.
module tb_ws2812b_rx;

    localparam int RST_CYC = 400;
    localparam int NPIX    = 8;
    localparam int GAP     = RST_CYC + 60;
    localparam int PER     = 62;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        data_in = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [6:0]  pix_idx;
    logic        frame_done;
    logic [6:0]  frame_pix;
    logic        err;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [30:0] exp_q[$];
    logic [6:0]  exp_frame_q[$];

    ws2812b_rx #(
        .TH_THRESH (30),
        .MIN_HIGH  (5),
        .MAX_HIGH  (60),
        .RST_CYC   (RST_CYC),
        .NPIX      (NPIX)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_in),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .frame_pix  (frame_pix),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expectations as the DUT strobes
    always @(negedge sys_clk) begin
        if (!sys_rst && (pix_valid || frame_done))
            check("strobe_overlap", 32'(pix_valid & frame_done), 32'd0);
        if (!sys_rst && pix_valid) begin
            if (exp_q.size() == 0) check("pix_unexpected", 32'(exp_q.size()), 32'd1);
            else check("pix_word", 32'({pix_idx, pix_data}), 32'(exp_q.pop_front()));
        end
        if (!sys_rst && frame_done) begin
            if (exp_frame_q.size() == 0) check("frame_unexpected", 32'(exp_frame_q.size()), 32'd1);
            else check("frame_pix", 32'(frame_pix), 32'(exp_frame_q.pop_front()));
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        data_in = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse(input int hi, input int per);
        data_in = 1'b1;
        repeat (hi) @(negedge sys_clk);
        data_in = 1'b0;
        repeat (per - hi) @(negedge sys_clk);
    endtask

    task automatic send_range(input logic [23:0] w, input int msb, input int lsb,
                              input int w0, input int w1);
        for (int i = msb; i >= lsb; i--) pulse(w[i] ? w1 : w0, PER);
    endtask

    task automatic send_pix(input logic [23:0] w);
        send_range(w, 23, 0, 20, 40);
    endtask

    task automatic end_phase(input string tag);
        check({tag, "_pix_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_left"}, 32'(exp_frame_q.size()), 32'd0);
        exp_q.delete();
        exp_frame_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_pix_idx"}, 32'(pix_idx), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_pix"}, 32'(frame_pix), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        logic [23:0] w;
        int          hi;

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check_cleared("reset");

        // Single pixel: frame closes with 1 of NPIX pixels, so err is set
        idle(GAP);
        exp_q.push_back({7'd0, 24'h00FF00});
        send_pix(24'h00FF00);
        exp_frame_q.push_back(7'd1);
        idle(GAP);
        end_phase("single");
        check("single_err", 32'(err), 32'd1);

        // Full frame of NPIX pixels
        do_reset();
        idle(GAP);
        for (int p = 0; p < NPIX; p++) begin
            w = 24'(p * 24'h010101);
            exp_q.push_back({7'(p), w});
            send_pix(w);
        end
        exp_frame_q.push_back(7'(NPIX));
        idle(GAP);
        end_phase("full");
        check("full_err", 32'(err), 32'd0);

        // Threshold: 29 cycles decodes 0, 30 decodes 1
        do_reset();
        idle(GAP);
        exp_q.push_back({7'd0, 24'h555555});
        send_range(24'h555555, 23, 0, 29, 30);
        idle(10);
        end_phase("thresh");
        check("thresh_err", 32'(err), 32'd0);
        pulse(4, PER);
        check("glitch_err", 32'(err), 32'd1);
        check("glitch_state", 32'(dbg_state), 32'd0);

        do_reset();
        idle(GAP);
        pulse(61, 100);
        check("long_err", 32'(err), 32'd1);
        check("long_state", 32'(dbg_state), 32'd0);

        // Partial pixel then a reset gap
        do_reset();
        idle(GAP);
        send_range(24'hABCDEF, 23, 12, 20, 40);
        exp_frame_q.push_back(7'd0);
        idle(GAP);
        end_phase("partial");
        check("partial_err", 32'(err), 32'd1);

        // Startup mid-word: nothing decodes until the first gap
        do_reset();
        send_range(24'h123456, 11, 0, 20, 40);
        send_pix(24'h654321);
        idle(GAP);
        end_phase("startup_pre");
        exp_q.push_back({7'd0, 24'hC0FFEE});
        send_pix(24'hC0FFEE);
        exp_frame_q.push_back(7'd1);
        idle(GAP);
        end_phase("startup");

        // sys_rst pulse during bit 10 of pixel 3
        do_reset();
        idle(GAP);
        for (int p = 0; p < 3; p++) begin
            w = 24'(p * 24'h010101);
            exp_q.push_back({7'(p), w});
            send_pix(w);
        end
        w = 24'h030303;
        send_range(w, 23, 14, 20, 40);
        hi = w[13] ? 40 : 20;
        data_in = 1'b1;
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_cleared("midrst");
        repeat (hi - 6) @(negedge sys_clk);
        data_in = 1'b0;
        repeat (PER - hi) @(negedge sys_clk);
        send_range(w, 12, 0, 20, 40);
        send_pix(24'h040404);
        idle(GAP);
        end_phase("midrst_pre");
        exp_q.push_back({7'd0, 24'h0A0B0C});
        send_pix(24'h0A0B0C);
        exp_frame_q.push_back(7'd1);
        idle(GAP);
        end_phase("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
